rx_uart: RTL

//  Serial UART receiver; consumes the line driven by tx_uart (loopback or external pin).

---
 rtl/rx_uart.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/rx_uart.sv
// rx_uart - oversampling UART receiver, LSB-first, mid-bit sampling.
// Optional even parity bit after the data when RX_PARITY_EN is defined.
module rx_uart #(
    parameter int DATA_BITS = 8,
    parameter int N_TICKS   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_ticks,
    input  logic                 i_data_in,
    output logic                 o_rx_done,
    output logic [DATA_BITS-1:0] o_data_out,
    output logic                 o_frame_err,
    output logic                 o_parity_err
);

    localparam int SW = (N_TICKS > 2) ? $clog2(N_TICKS) : 1;
    localparam int NW = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;
    localparam logic [SW-1:0] S_MID  = SW'(N_TICKS / 2 - 1);
    localparam logic [SW-1:0] S_END  = SW'(N_TICKS - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

`ifdef RX_PARITY_EN
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

    state_t                 state_q, state_d;
    logic                   sync1_q, sync2_q;
    logic [SW-1:0]          s_q, s_d;
    logic [NW-1:0]          n_q, n_d;
    logic [DATA_BITS-1:0]   b_q, b_d;
    logic                   armed_q, armed_d;
    logic                   rx_done_q, rx_done_d;
    logic [DATA_BITS-1:0]   data_out_q, data_out_d;
    logic                   frame_err_q, frame_err_d;
    logic                   rx;

    assign rx = sync2_q;

`ifdef RX_PARITY_EN
    logic perr_q, perr_d;
    logic parity_err_q, parity_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        n_d         = n_q;
        b_d         = b_q;
        armed_d     = armed_q;
        rx_done_d   = 1'b0;
        data_out_d  = data_out_q;
        frame_err_d = frame_err_q;
`ifdef RX_PARITY_EN
        perr_d       = perr_q;
        parity_err_d = parity_err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (rx) armed_d = 1'b1;
                if (armed_q && !rx) begin
                    state_d = ST_START;
                    s_d     = '0;
                end
            end
            ST_START: if (i_ticks) begin
                if (s_q == S_MID) begin
                    // A start bit that is high again at mid-bit was a glitch.
                    if (!rx) begin
                        state_d = ST_DATA;
                        s_d     = '0;
                        n_d     = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    s_d = s_q + 1'b1;
                end
            end
            ST_DATA: if (i_ticks) begin
                if (s_q == S_END) begin
                    b_d = {rx, b_q[DATA_BITS-1:1]};
                    s_d = '0;
                    if (n_q == N_LAST) begin
`ifdef RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        n_d = n_q + 1'b1;
                    end
                end else begin
                    s_d = s_q + 1'b1;
                end
            end
`ifdef RX_PARITY_EN
            ST_PARITY: if (i_ticks) begin
                if (s_q == S_END) begin
                    perr_d  = (^b_q) ^ rx;
                    s_d     = '0;
                    state_d = ST_STOP;
                end else begin
                    s_d = s_q + 1'b1;
                end
            end
`endif
            ST_STOP: if (i_ticks) begin
                if (s_q == S_END) begin
                    // Disarm so a held break cannot produce a second frame.
                    rx_done_d   = 1'b1;
                    data_out_d  = b_q;
                    frame_err_d = ~rx;
`ifdef RX_PARITY_EN
                    parity_err_d = perr_q;
`endif
                    armed_d     = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    s_d = s_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            s_q         <= '0;
            n_q         <= '0;
            b_q         <= '0;
            armed_q     <= 1'b0;
            rx_done_q   <= 1'b0;
            data_out_q  <= '0;
            frame_err_q <= 1'b0;
`ifdef RX_PARITY_EN
            perr_q       <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sync1_q     <= i_data_in;
            sync2_q     <= sync1_q;
            s_q         <= s_d;
            n_q         <= n_d;
            b_q         <= b_d;
            armed_q     <= armed_d;
            rx_done_q   <= rx_done_d;
            data_out_q  <= data_out_d;
            frame_err_q <= frame_err_d;
`ifdef RX_PARITY_EN
            perr_q       <= perr_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign o_rx_done   = rx_done_q;
    assign o_data_out  = data_out_q;
    assign o_frame_err = frame_err_q;
`ifdef RX_PARITY_EN
    assign o_parity_err = parity_err_q;
`else
    assign o_parity_err = 1'b0;
`endif

endmodule
